// File: rtl/debounce_pkg.sv
// Shared types and default sizing for the input debouncer and its synchronizer.
package debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous input; output is the last stage.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_out
);

  if (STAGES < 2) begin : g_bad_stages
    $fatal(1, "sync_chain: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_in};
    end
  end

  assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a raw async line, then only lets a level change through once it has
// disagreed with the current output for DEBOUNCE_CYCLES consecutive samples.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q,
  output logic qbar,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $fatal(1, "debounce_sync: DEBOUNCE_CYCLES must be >= 1");
  end

  logic             d_s;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             qbar_q, qbar_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             flip;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_async),
    .d_out(d_s)
  );

  // Mismatch is always judged against the current q, so a reversal cancels the run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    case (state_q)
      STABLE: begin
        if (d_s != q_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            flip = 1'b1;
          end else begin
            state_d = PENDING;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PENDING: begin
        if (d_s == q_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          flip    = 1'b1;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase

    q_d    = flip ? ~q_q : q_q;
    qbar_d = flip ? q_q : qbar_q;
    rise_d = flip & ~q_q;
    fall_d = flip & q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      qbar_q  <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      qbar_q  <= qbar_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q    = q_q;
  assign qbar = qbar_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == PENDING);

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Input conditioner that sits directly upstream of the team's D flip-flop stage.
- Takes a raw asynchronous, possibly glitchy data line and passes it through a synchronizer chain, then a counter-based debouncer.
- Produces a clean, clock-aligned level plus single-cycle rise/fall strobes.
- Its q output is the d input of the downstream flip-flop. Downstream therefore only ever sees changes that are clock-aligned and stable for DEBOUNCE_CYCLES.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops; must be >= 2 (elaboration-time check, $fatal otherwise).
- DEBOUNCE_CYCLES, 4: consecutive mismatching synchronized samples required before q flips; must be >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- d_async  input  1  raw asynchronous data; no timing relation to clk.
- q  output  1  debounced, synchronized level.
- qbar  output  1  always ~q, registered alongside q.
- rise  output  1  one-cycle pulse on the edge where q goes 0->1.
- fall  output  1  one-cycle pulse on the edge where q goes 1->0.
- busy  output  1  high while a change is pending (state PENDING).

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately regardless of clk):
  - All sync flops = 0, cnt = 0, state = STABLE.
  - q = 0, qbar = 1, rise = 0, fall = 0, busy = 0.
- Reset release: the first update occurs on the first rising clk edge with rst=0. There is no release synchronizer inside this block; rst deassertion timing is the integrator's responsibility.
- Synchronizer: sync[0] <= d_async, sync[i] <= sync[i-1]; d_s = sync[SYNC_STAGES-1]. Only d_s feeds later logic; no combinational path from d_async.
- FSM, state STABLE (cnt = 0, busy = 0):
  - d_s == q: remain in STABLE.
  - d_s != q and DEBOUNCE_CYCLES == 1: flip q on this edge and remain in STABLE.
  - d_s != q otherwise: go to PENDING with cnt = 1.
- FSM, state PENDING (busy = 1):
  - d_s == q (glitch ended): return to STABLE, cnt = 0, no output change.
  - d_s != q and cnt == DEBOUNCE_CYCLES-1: flip q on this edge, return to STABLE, cnt = 0.
  - Otherwise: cnt <= cnt + 1.
- Flip action (registered, same edge):
  - q <= ~q, qbar <= q.
  - rise <= ~q (q was 0), fall <= q (q was 1).
  - On every non-flip edge, rise = fall = 0. rise and fall are never both 1.
- Latency: a d_async change meeting setup before edge E, held stable, updates q, qbar and rise/fall on edge E + SYNC_STAGES + DEBOUNCE_CYCLES - 1. With defaults, that is the 6th rising edge counting E as the 1st.
- Filtering: any d_s excursion shorter than DEBOUNCE_CYCLES cycles is discarded entirely, with no pulse. busy still asserts during the excursion.
- Mismatch is always measured against the current q, so opposite-direction glitches cannot accumulate.
- cnt never exceeds DEBOUNCE_CYCLES-1 and does not wrap.
- Reset asserted mid-PENDING: immediate return to the reset values; the pending change is lost.
- Metastability: functional sims treat sync[0] as ideal. Random d_async edge placement must not break the latency bound by more than 1 cycle.

Decomposition:
- Package debounce_pkg:
  - typedef enum logic {STABLE, PENDING} db_state_t.
  - Localparam defaults SYNC_STAGES_DEF = 2 and DEBOUNCE_CYCLES_DEF = 4.
- One sub-module, sync_chain:
  - Parameter STAGES; ports clk, rst, d_in, d_out.
  - Async active-high reset to 0.
  - Reused elsewhere for other async inputs.
- debounce_sync instantiates sync_chain and contains the FSM, counter and output registers.

Test Plan (defaults, clk period 1 ns, timescale 1ns/1ps):
- Reset hold: rst=1 for 3 ns while toggling d_async -> q=0, qbar=1, rise=fall=busy=0 throughout, including immediately on rst assertion mid-cycle.
- Clean rise: after reset release, d_async 0->1 just before edge E and held -> q=1, qbar=0 at edge E+5, rise=1 for exactly that one cycle, busy high for the 3 cycles before the flip.
- Glitch reject: d_async=1 for 2 ns then back to 0 -> q stays 0, rise/fall never assert, busy pulses and returns to 0.
- Clean fall: with q=1, d_async 1->0 held -> q=0 at E+5, fall=1 for one cycle, rise stays 0.
- Reset mid-pending: d_async 0->1, assert rst 4 ns later (PENDING, cnt=2) -> q=0 and busy=0 immediately. After release with d_async still 1 -> q=1 after a full SYNC_STAGES+DEBOUNCE_CYCLES edges.
- Random toggling: loop of 20 d_async toggles with $urandom_range(1,8) ns gaps, scoreboard model -> q changes only after 4 stable synchronized cycles, q == ~qbar every cycle, one rise/fall pulse per q change, never both together.
